rand_requester: RTL and testbench

RAND_REQUESTER -- requirements
Module: rand_requester

---
 rtl/rand_requester_if.sv | 30 +++
 rtl/rand_requester.sv | 81 ++++++++
 tb/tb_rand_requester.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rand_requester_if.sv
// rand_requester_if: burst control, generator request/response and dequeue port bundle.
// STAT_WORDS is only present when RAND_REQ_STATS_EN is defined.
interface rand_requester_if;
    logic        start;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        req_write;
    logic [31:0] resp_read;
    logic        deq_valid;
    logic [31:0] deq_data;
    logic        deq_ready;
`ifdef RAND_REQ_STATS_EN
    logic [31:0] stat_words;
`endif
    modport slave (
        input  start, count, resp_read, deq_ready,
        output busy, done, req_write, deq_valid, deq_data
`ifdef RAND_REQ_STATS_EN
        , output stat_words
`endif
    );
    modport master (
        output start, count, resp_read, deq_ready,
        input  busy, done, req_write, deq_valid, deq_data
`ifdef RAND_REQ_STATS_EN
        , input stat_words
`endif
    );
endinterface

// File: rtl/rand_requester.sv
// rand_requester: issues COUNT generator requests under buffer credit and queues the 1-cycle-latency replies.
// Optional popped-word counter on STAT_WORDS enabled by RAND_REQ_STATS_EN.
module rand_requester #(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    rand_requester_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic        inflight_q;
    logic        done_q, done_d;
    logic [AW:0] occ_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [31:0] mem_q [DEPTH];
    logic        req, push, pop;
    // credit counts the word already requested but not yet pushed
    assign req  = state_q == RUN && rem_q != 16'd0 &&
                  (occ_q + (AW+1)'(inflight_q)) < (AW+1)'(DEPTH);
    assign push = inflight_q;
    assign pop  = occ_q != '0 && bus.deq_ready;
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = bus.count != 16'd0 ? RUN : IDLE;
                rem_d   = bus.count;
                done_d  = bus.count == 16'd0;
            end
            RUN: if (req) begin
                rem_d   = rem_q - 16'd1;
                state_d = rem_q == 16'd1 ? DRAIN : RUN;
            end
            DRAIN: if (!inflight_q && occ_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            occ_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            inflight_q <= req;
            done_q     <= done_d;
            occ_q      <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
            wr_q       <= wr_q + AW'(push);
            rd_q       <= rd_q + AW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.resp_read;
    end
`ifdef RAND_REQ_STATS_EN
    logic [31:0] stat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_q + 32'(pop);
    end
    assign bus.stat_words = stat_q;
`endif
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;
    assign bus.req_write = req;
    assign bus.deq_valid = occ_q != '0;
    assign bus.deq_data  = occ_q != '0 ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_rand_requester.sv
// tb_rand_requester: directed bursts against a 1-cycle generator model and an in-order consumer scoreboard.
module tb_rand_requester;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    rand_requester_if bus();
    rand_requester #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0, bad = 0;
    int n_req, n_pop, n_done, run, max_run, occ_m, max_occ, gen_n;
    logic gen_prev = 1'b0, mon_prev = 1'b0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        n_req = 0; n_pop = 0; n_done = 0; run = 0; max_run = 0; max_occ = 0; gen_n = 0;
    endtask
    task automatic go(input logic [15:0] c);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.count = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input int lim);
        int i = 0;
        int d0 = n_done;
        while (i < lim && n_done == d0) begin
            @(posedge clk); #1;
            i++;
        end
        chk("done_timeout", 32'(n_done != d0), 32'd1);
    endtask
    // generator: word n (from 0) is 0x11*(n+1), presented the cycle after its request
    initial begin
        bus.resp_read = '0;
        forever @(negedge clk) begin
            if (!rst_n) gen_prev = 1'b0;
            else begin
                if (gen_prev) begin
                    bus.resp_read = 32'h11 * (gen_n + 1);
                    gen_n++;
                end
                gen_prev = bus.req_write;
            end
        end
    end
    initial begin
        forever @(negedge clk) begin
            if (!rst_n) begin
                occ_m = 0; mon_prev = 1'b0; run = 0;
            end else begin
                chk("deq_valid", 32'(bus.deq_valid), 32'(occ_m != 0));
                if (bus.deq_valid && bus.deq_ready) begin
                    chk("deq_data", bus.deq_data, 32'h11 * (n_pop + 1));
                    n_pop++;
                end
                if (bus.req_write) begin
                    n_req++; run++;
                    if (run > max_run) max_run = run;
                end else run = 0;
                if (bus.done) n_done++;
                occ_m += int'(mon_prev) - int'(bus.deq_valid && bus.deq_ready);
                if (occ_m > max_occ) max_occ = occ_m;
                if (occ_m > 4) chk("overflow", 32'(occ_m), 32'd4);
                mon_prev = bus.req_write;
            end
        end
    end
    initial begin
        bus.start = 1'b0; bus.count = '0; bus.deq_ready = 1'b0;
        clr();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_req", 32'(bus.req_write), 0);
        chk("rst_valid", 32'(bus.deq_valid), 0);
        chk("rst_data", bus.deq_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // three words, consumer always ready
        clr(); bus.deq_ready = 1'b1;
        go(16'd3);
        wait_done(50);
        chk("t1_req", 32'(n_req), 3);
        chk("t1_run", 32'(max_run), 3);
        chk("t1_pop", 32'(n_pop), 3);
        chk("t1_busy", 32'(bus.busy), 0);
        repeat (3) @(posedge clk); #1;
        chk("t1_done", 32'(n_done), 1);
        // ten words with stalled consumer
        clr(); bus.deq_ready = 1'b0;
        go(16'd10);
        repeat (15) @(posedge clk); #1;
        chk("t2_stall_req", 32'(n_req), 4);
        chk("t2_stall_busy", 32'(bus.busy), 1);
        bus.deq_ready = 1'b1;
        wait_done(100);
        chk("t2_req", 32'(n_req), 10);
        chk("t2_pop", 32'(n_pop), 10);
        chk("t2_max_occ", 32'(max_occ), 4);
        repeat (3) @(posedge clk); #1;
        chk("t2_done", 32'(n_done), 1);
        // zero-length burst
        clr();
        go(16'd0);
        chk("t3_done_hi", 32'(bus.done), 1);
        chk("t3_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        chk("t3_done_lo", 32'(bus.done), 0);
        chk("t3_req", 32'(n_req), 0);
        chk("t3_done_n", 32'(n_done), 1);
        // reset in the middle of an eight-word burst
        clr();
        go(16'd8);
        for (int i = 0; i < 40 && n_req < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("t4_req5", 32'(n_req), 5);
        rst_n = 1'b0;
        #1;
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_req", 32'(bus.req_write), 0);
        chk("t4_valid", 32'(bus.deq_valid), 0);
        chk("t4_data", bus.deq_data, 0);
        chk("t4_done", 32'(bus.done), 0);
        repeat (2) @(posedge clk); #1;
        chk("t4_no_done", 32'(n_done), 0);
        clr();
        rst_n = 1'b1;
        go(16'd2);
        wait_done(50);
        chk("t4_new_req", 32'(n_req), 2);
        chk("t4_new_pop", 32'(n_pop), 2);
        // full buffer, consumer toggling, START pulses while busy
        clr(); bus.deq_ready = 1'b0;
        go(16'd12);
        repeat (10) @(posedge clk); #1;
        chk("t5_full_req", 32'(n_req), 4);
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            @(posedge clk); #1;
            bus.deq_ready = ~bus.deq_ready;
            bus.start = (i % 7 == 3) && bus.busy;
            bus.count = 16'd1;
        end
        bus.start = 1'b0; bus.deq_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("t5_req", 32'(n_req), 12);
        chk("t5_pop", 32'(n_pop), 12);
        chk("t5_done", 32'(n_done), 1);
        chk("t5_max_occ", 32'(max_occ), 4);
        chk("t5_busy", 32'(bus.busy), 0);
        // two bursts after a fresh reset: 3 + 5 words
        rst_n = 1'b0;
        @(posedge clk); #1;
        clr();
        rst_n = 1'b1;
        go(16'd3);
        wait_done(50);
        go(16'd5);
        wait_done(50);
        chk("t6_pop", 32'(n_pop), 8);
`ifdef RAND_REQ_STATS_EN
        chk("t6_stat", bus.stat_words, 32'd8);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
